// File: rtl/bt_update_queue_pkg.sv
// Shared core types for the branch-target update queue: the BTUpdate record,
// the fetch-offset type and the drop counter width.
package bt_update_queue_pkg;

  localparam int DROP_CNT_W = 16;

  typedef logic [2:0] FetchOff_t;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic        isJump;
    logic        isCall;
    logic        compressed;
    logic        clean;
    logic        multiple;
    FetchOff_t   multipleOffs;
    FetchOff_t   fetchStartOffs;
    logic        valid;
  } BTUpdate;

  // A newer record for the same source replaces the target info but keeps src, clean and valid.
  function automatic BTUpdate merge_rec(input BTUpdate old_rec, input BTUpdate new_rec);
    BTUpdate r;
    r                = old_rec;
    r.dst            = new_rec.dst;
    r.isJump         = new_rec.isJump;
    r.isCall         = new_rec.isCall;
    r.compressed     = new_rec.compressed;
    r.multiple       = new_rec.multiple;
    r.multipleOffs   = new_rec.multipleOffs;
    r.fetchStartOffs = new_rec.fetchStartOffs;
    return r;
  endfunction

endpackage

// File: rtl/bt_update_queue_compact.sv
// Combinational compactor: packs the valid input records to the low slots in
// ascending port order and reports how many there are.
module bt_update_compact
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int CNT_W  = $clog2(NUM_IN + 1)
) (
  input  BTUpdate [NUM_IN-1:0] recs,
  output BTUpdate [NUM_IN-1:0] packed_recs,
  output logic    [CNT_W-1:0]  rec_cnt
);

  int pos_s;

  // Slot j receives the j-th valid input.
  always_comb begin
    packed_recs = '0;
    pos_s       = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (recs[i].valid && (j == pos_s)) begin
          packed_recs[j] = recs[i];
        end else begin
          packed_recs[j] = packed_recs[j];
        end
      end
      pos_s = pos_s + (recs[i].valid ? 1 : 0);
    end
    rec_cnt = CNT_W'(pos_s);
  end

endmodule

// File: rtl/bt_update_queue.sv
// Circular FIFO collecting BTB update records from several ALUs and draining
// one per cycle to the BTB. Optional same-source merging under BTUQ_MERGE_EN.
module bt_update_queue
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  BTUpdate [NUM_IN-1:0]     IN_btUpdates,
  input  logic                     IN_btReady,
  input  logic                     IN_clear,
  output BTUpdate                  OUT_btUpdate,
  output logic                     OUT_dropped,
  output logic [DROP_CNT_W-1:0]    OUT_dropCnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_IN + 1);

  BTUpdate               mem_r [DEPTH];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW:0]           count_r;
  logic                  dropped_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  BTUpdate [NUM_IN-1:0]  packed_s;
  logic [CW-1:0]         rec_cnt_s;
  BTUpdate               wmem_s [DEPTH];
  logic [PW-1:0]         wp_s;
  logic                  deq_s;
  logic                  hit_s;
  int                    free_s;
  int                    n_enq_s;
  int                    n_drop_s;
  logic [PW:0]           count_nxt_s;
  logic [DROP_CNT_W:0]   drop_sum_s;
`ifdef BTUQ_MERGE_EN
  logic [DEPTH-1:0]      live_s;
`endif

  bt_update_compact #(
    .NUM_IN (NUM_IN),
    .CNT_W  (CW)
  ) u_compact (
    .recs        (IN_btUpdates),
    .packed_recs (packed_s),
    .rec_cnt     (rec_cnt_s)
  );

  // Next storage image, write pointer and enqueue/drop counts for this cycle.
  always_comb begin
    deq_s   = (count_r != '0) && IN_btReady;
    free_s  = DEPTH - int'(count_r) + (deq_s ? 1 : 0);
    wp_s    = wr_ptr_r;
    n_enq_s = 0;
    n_drop_s = 0;
    hit_s   = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      wmem_s[s] = mem_r[s];
    end
`ifdef BTUQ_MERGE_EN
    // The head leaving this cycle is no longer a merge candidate.
    for (int s = 0; s < DEPTH; s++) begin
      live_s[s] = ({1'b0, PW'(PW'(s) - rd_ptr_r)} < count_r) && !(deq_s && (PW'(s) == rd_ptr_r));
    end
`endif
    for (int j = 0; j < NUM_IN; j++) begin
      hit_s = 1'b0;
`ifdef BTUQ_MERGE_EN
      for (int s = 0; s < DEPTH; s++) begin
        if ((j < int'(rec_cnt_s)) && !hit_s && live_s[s] && (wmem_s[s].src == packed_s[j].src)) begin
          hit_s     = 1'b1;
          wmem_s[s] = merge_rec(wmem_s[s], packed_s[j]);
        end else begin
          hit_s = hit_s;
        end
      end
`endif
      if ((j < int'(rec_cnt_s)) && !hit_s) begin
        if (n_enq_s < free_s) begin
          wmem_s[wp_s] = packed_s[j];
`ifdef BTUQ_MERGE_EN
          live_s[wp_s] = 1'b1;
`endif
          wp_s    = wp_s + PW'(1);
          n_enq_s = n_enq_s + 1;
        end else begin
          n_drop_s = n_drop_s + 1;
        end
      end else begin
        n_enq_s = n_enq_s;
      end
    end
    count_nxt_s = count_r + (PW+1)'(n_enq_s) - (PW+1)'(deq_s);
    drop_sum_s  = {1'b0, drop_cnt_r} + (DROP_CNT_W+1)'(n_drop_s);
  end

  // Control state: pointers, occupancy and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      dropped_r  <= 1'b0;
      drop_cnt_r <= '0;
    end else if (IN_clear) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      dropped_r  <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_r + PW'(deq_s);
      wr_ptr_r   <= wp_s;
      count_r    <= count_nxt_s;
      dropped_r  <= (n_drop_s != 0);
      drop_cnt_r <= drop_sum_s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  // Record storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && !IN_clear) begin
      for (int s = 0; s < DEPTH; s++) begin
        mem_r[s] <= wmem_s[s];
      end
    end
  end

  // Head entry straight from storage.
  always_comb begin
    OUT_btUpdate       = mem_r[rd_ptr_r];
    OUT_btUpdate.valid = (count_r != '0);
  end

  assign OUT_dropped = dropped_r;
  assign OUT_dropCnt = drop_cnt_r;

endmodule

// File: tb/tb_bt_update_queue.sv
// Bench for bt_update_queue: directed vector table, drop-counter saturation,
// merge sequence and randomized traffic against a queue-based reference model.
module tb_bt_update_queue;
  import bt_update_queue_pkg::*;

  localparam int NUM_IN = 2;
  localparam int DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  BTUpdate [NUM_IN-1:0]  IN_btUpdates;
  logic                  IN_btReady;
  logic                  IN_clear;
  BTUpdate               OUT_btUpdate;
  logic                  OUT_dropped;
  logic [15:0]           OUT_dropCnt;

  int checks = 0;
  int errors = 0;

  BTUpdate     mq[$];
  logic        m_dropped = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  typedef struct {
    logic        v0;
    logic [31:0] s0;
    logic        v1;
    logic [31:0] s1;
    logic        rdy;
    logic        clr;
    logic        rs;
    logic        e_valid;
    logic [31:0] e_src;
    logic        e_drop;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[22];

  always #5 clk = ~clk;

  bt_update_queue #(.NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_btUpdates (IN_btUpdates),
    .IN_btReady   (IN_btReady),
    .IN_clear     (IN_clear),
    .OUT_btUpdate (OUT_btUpdate),
    .OUT_dropped  (OUT_dropped),
    .OUT_dropCnt  (OUT_dropCnt)
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic BTUpdate mk(input logic v, input logic [31:0] s, input logic [31:0] d);
    BTUpdate r;
    r       = '0;
    r.valid = v;
    r.src   = s;
    r.dst   = d;
    return r;
  endfunction

  function automatic vec_t mkv(input logic v0, input logic [31:0] s0, input logic v1, input logic [31:0] s1,
                               input logic rdy, input logic clr, input logic rs,
                               input logic ev, input logic [31:0] es, input logic ed, input logic [15:0] ec);
    vec_t v;
    v.v0 = v0; v.s0 = s0; v.v1 = v1; v.s1 = s1;
    v.rdy = rdy; v.clr = clr; v.rs = rs;
    v.e_valid = ev; v.e_src = es; v.e_drop = ed; v.e_cnt = ec;
    return v;
  endfunction

  function automatic BTUpdate rnd_rec();
    BTUpdate r;
    r.src            = 32'($urandom_range(0, 7)) << 4;
    r.dst            = $urandom();
    r.isJump         = 1'($urandom_range(0, 1));
    r.isCall         = 1'($urandom_range(0, 1));
    r.compressed     = 1'($urandom_range(0, 1));
    r.clean          = 1'($urandom_range(0, 1));
    r.multiple       = 1'($urandom_range(0, 1));
    r.multipleOffs   = 3'($urandom_range(0, 7));
    r.fetchStartOffs = 3'($urandom_range(0, 7));
    r.valid          = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  // Reference: the queue as an ordered list; drain first, then accept inputs while room remains.
  function automatic void model_step(input BTUpdate i0, input BTUpdate i1, input logic rdy, input logic clr, input logic rs);
    BTUpdate ins[2];
    int drops;
    int total;
    ins[0] = i0;
    ins[1] = i1;
    drops  = 0;
    if (rs) begin
      mq.delete();
      m_dropped = 1'b0;
      m_cnt     = 16'h0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (clr) begin
        mq.delete();
        m_dropped = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (ins[i].valid) begin
            bit hit;
            hit = 1'b0;
`ifdef BTUQ_MERGE_EN
            for (int k = 0; k < mq.size(); k++) begin
              if (!hit && mq[k].src == ins[i].src) begin
                hit                  = 1'b1;
                mq[k].dst            = ins[i].dst;
                mq[k].isJump         = ins[i].isJump;
                mq[k].isCall         = ins[i].isCall;
                mq[k].compressed     = ins[i].compressed;
                mq[k].multiple       = ins[i].multiple;
                mq[k].multipleOffs   = ins[i].multipleOffs;
                mq[k].fetchStartOffs = ins[i].fetchStartOffs;
              end
            end
`endif
            if (!hit) begin
              if (mq.size() < DEPTH) mq.push_back(ins[i]);
              else drops++;
            end
          end
        end
        m_dropped = (drops != 0);
        total     = int'(m_cnt) + drops;
        m_cnt     = (total > 65535) ? 16'hFFFF : 16'(total);
      end
    end
  endfunction

  task automatic step(input BTUpdate i0, input BTUpdate i1, input logic rdy, input logic clr, input logic rs);
    IN_btUpdates[0] = i0;
    IN_btUpdates[1] = i1;
    IN_btReady      = rdy;
    IN_clear        = clr;
    rst             = rs;
    @(posedge clk);
    model_step(i0, i1, rdy, clr, rs);
    @(negedge clk);
  endtask

  task automatic check_model();
    BTUpdate exp;
    chk("model_valid", 128'(OUT_btUpdate.valid), 128'(mq.size() != 0));
    if (mq.size() != 0) begin
      exp       = mq[0];
      exp.valid = 1'b1;
      chk("model_head", 128'(OUT_btUpdate), 128'(exp));
    end
    chk("model_dropped", 128'(OUT_dropped), 128'(m_dropped));
    chk("model_dropcnt", 128'(OUT_dropCnt), 128'(m_cnt));
  endtask

  initial begin
    BTUpdate nul;
    BTUpdate a;
    BTUpdate b;
    int n;
    logic [31:0] first_dst;
    nul = '0;
    IN_btUpdates = '0;
    IN_btReady = 1'b0;
    IN_clear = 1'b0;
    rst = 1'b1;

    //            v0   s0          v1   s1     rdy  clr  rs   ev   esrc        edrop cnt
    tbl[0]  = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 16'd0);
    tbl[1]  = mkv(1'b1, 32'h1000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 16'd0);
    tbl[2]  = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 16'd0);
    tbl[3]  = mkv(1'b1, 32'h10,   1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,   1'b0, 16'd0);
    tbl[4]  = mkv(1'b1, 32'h30,   1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,   1'b0, 16'd0);
    tbl[5]  = mkv(1'b1, 32'h50,   1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,   1'b1, 16'd2);
    tbl[6]  = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h10,   1'b0, 16'd2);
    tbl[7]  = mkv(1'b1, 32'h50,   1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h20,   1'b0, 16'd2);
    tbl[8]  = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h30,   1'b0, 16'd2);
    tbl[9]  = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h40,   1'b0, 16'd2);
    tbl[10] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h50,   1'b0, 16'd2);
    tbl[11] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 16'd2);
    tbl[12] = mkv(1'b1, 32'h11,   1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,   1'b0, 16'd2);
    tbl[13] = mkv(1'b1, 32'h33,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h11,   1'b0, 16'd2);
    tbl[14] = mkv(1'b1, 32'h44,   1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 16'd2);
    tbl[15] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 16'd2);
    tbl[16] = mkv(1'b1, 32'h66,   1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66,   1'b0, 16'd2);
    tbl[17] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 16'd0);
    tbl[18] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 16'd0);
    tbl[19] = mkv(1'b0, 32'h0,    1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b1, 32'h88,   1'b0, 16'd0);
    tbl[20] = mkv(1'b1, 32'h99,   1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h99,   1'b0, 16'd0);
    tbl[21] = mkv(1'b0, 32'h0,    1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 16'd0);

    for (int r = 0; r < 22; r++) begin
      step(mk(tbl[r].v0, tbl[r].s0, tbl[r].s0 << 1), mk(tbl[r].v1, tbl[r].s1, tbl[r].s1 << 1),
           tbl[r].rdy, tbl[r].clr, tbl[r].rs);
      chk($sformatf("vec%0d_valid", r), 128'(OUT_btUpdate.valid), 128'(tbl[r].e_valid));
      if (tbl[r].e_valid) begin
        chk($sformatf("vec%0d_src", r), 128'(OUT_btUpdate.src), 128'(tbl[r].e_src));
        chk($sformatf("vec%0d_dst", r), 128'(OUT_btUpdate.dst), 128'(tbl[r].e_src << 1));
      end
      chk($sformatf("vec%0d_dropped", r), 128'(OUT_dropped), 128'(tbl[r].e_drop));
      chk($sformatf("vec%0d_dropcnt", r), 128'(OUT_dropCnt), 128'(tbl[r].e_cnt));
    end

    // Drop counter saturation: 2 drops per cycle once the queue is full.
    step(nul, nul, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 32772; c++) begin
      step(mk(1'b1, 32'(c) << 4, 32'h1), mk(1'b1, (32'(c) << 4) + 32'h8, 32'h2), 1'b0, 1'b0, 1'b0);
    end
    chk("sat_dropcnt", 128'(OUT_dropCnt), 128'(16'hFFFF));
    chk("sat_dropped", 128'(OUT_dropped), 128'(1'b1));
    step(mk(1'b1, 32'h7770, 32'h1), nul, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", 128'(OUT_dropCnt), 128'(16'hFFFF));
    check_model();

    // Same-source sequence: merges in place when merging is built in.
    step(nul, nul, 1'b0, 1'b0, 1'b1);
    step(mk(1'b1, 32'h80, 32'h100), nul, 1'b0, 1'b0, 1'b0);
    step(mk(1'b1, 32'h80, 32'h200), nul, 1'b0, 1'b0, 1'b0);
    n = 0;
    first_dst = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (OUT_btUpdate.valid) begin
        if (n == 0) first_dst = OUT_btUpdate.dst;
        n++;
      end
      step(nul, nul, 1'b1, 1'b0, 1'b0);
    end
`ifdef BTUQ_MERGE_EN
    chk("merge_count", 128'(n), 128'(1));
    chk("merge_dst", 128'(first_dst), 128'(32'h200));
`else
    chk("dup_count", 128'(n), 128'(2));
    chk("dup_dst", 128'(first_dst), 128'(32'h100));
`endif

    // Randomized traffic against the reference model.
    step(nul, nul, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      a = rnd_rec();
      b = rnd_rec();
      step(a, b, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 199) == 0));
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
